au_add_seq: RTL
===============

AU_ADD_SEQ -- requirements
Module: AU_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand word length (>= 1).
REQ-002 SHALL have parameter DIGIT, default 4, bits added per cycle (1..WIDTH, WIDTH mod DIGIT = 0); N = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  addend.
REQ-008 SHALL have port b  input  WIDTH  addend.
REQ-009 SHALL have port ci  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port s  output  WIDTH  sum a+b+ci mod 2^WIDTH.
REQ-013 SHALL have port co  output  1  carry-out.
REQ-014 SHALL have port z  output  1  1 iff s is all zeros.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; one-hot or binary encoding is free.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept operands on a rising edge with in_valid & in_ready: latch a, b, ci; clear digit counter; go to CALC.
REQ-018 SHALL in CALC add one DIGIT-bit slice per cycle, LSB slice first, carry registered between slices.
REQ-019 SHALL go from CALC to DONE on the edge completing slice N-1; out_valid rises exactly N cycles after the accept edge.
REQ-020 SHALL compute z as the AND of per-slice all-zero flags, accumulated alongside the sum, no final WIDTH-bit compare.
REQ-021 SHALL hold s, co, z stable in DONE until out_valid & out_ready; then go to IDLE on that edge.
REQ-022 SHALL NOT accept new operands in the same cycle a result is consumed (in_ready = 0 in DONE); minimum initiation interval N+2 cycles.
REQ-023 SHALL ignore a, b, ci, in_valid while in CALC or DONE; latched operands not disturbed.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL, when N = 1, pass through CALC for exactly one cycle (latency 1).
REQ-026 SHALL keep s, co, z at their last completed values in IDLE and CALC; only out_valid qualifies them.
REQ-027 SHALL wrap modulo 2^WIDTH: overflow reported solely via co.

Reset
REQ-028 SHALL on rst = 1 asynchronously enter IDLE and clear s, co, z, counter, carry and operand registers to 0.
REQ-029 SHALL give after reset in_ready = 1, out_valid = 0.
REQ-030 SHALL abort any calculation or held result when rst asserts mid-operation; no result is emitted for it.

Structure
REQ-031 SHALL place state encoding constants and the N / counter-width derivation in the shared package AU_pkg.
REQ-032 SHALL use one sub-module AU_add_digit: combinational DIGIT-bit adder with carry-in, outputs slice sum, carry-out, slice-zero flag.
REQ-033 SHALL keep all registers in AU_add_seq; AU_add_digit contains no storage.

Verification
REQ-034 SHALL test WIDTH=8, DIGIT=4: a=0x7F, b=0x01, ci=0 -> after 2 cycles out_valid=1, s=0x80, co=0, z=0.
REQ-035 SHALL test WIDTH=8, DIGIT=4: a=0xFF, b=0x00, ci=1 -> s=0x00, co=1, z=1 (zero via wrap).
REQ-036 SHALL test back-pressure: out_ready=0 for 5 cycles in DONE -> s/co/z/out_valid stable, in_ready=0, new in_valid ignored.
REQ-037 SHALL test rst pulse in CALC cycle 1 -> in_ready=1, out_valid=0, s=0 next cycle; following op a=0x12, b=0x34 -> s=0x46, z=0.
REQ-038 SHALL test WIDTH=8, DIGIT=8 (N=1) and DIGIT=1 (N=8): a=0xAA, b=0x56, ci=0 -> s=0x00, co=1, z=1 at latency 1 and 8 respectively.
REQ-039 SHALL test random back-to-back ops against a+b+ci reference model, checking latency N and z == (s == 0).

Source files
------------

// File: rtl/au_add_seq_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// the slice-count / counter-width derivation used by au_add_seq.
package au_pkg;

  // Controller states. The encoding is binary; only these three are legal.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of DIGIT-bit slices making up one WIDTH-bit operand.
  function automatic int slice_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Width of the slice counter; at least one bit even when there is a single slice.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/au_add_seq_digit.sv
// One DIGIT-bit slice of the serial adder: purely combinational.
// Produces the slice sum, the carry into the next slice and a flag
// telling whether this slice of the sum is all zeros.
module au_add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             zero
);

  logic [DIGIT:0] total;

  // Slice addition with one extra bit to capture the carry-out.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  end

  assign s    = total[DIGIT-1:0];
  assign co   = total[DIGIT];
  assign zero = ~|total[DIGIT-1:0];

endmodule

// File: rtl/au_add_seq.sv
// Digit-serial adder: accepts a, b, ci with a valid/ready handshake, adds
// one DIGIT-bit slice per clock (LSB first, carry held in a register) and
// presents s, co, z with a valid/ready handshake. The zero flag is built up
// slice by slice rather than by comparing the whole sum at the end.
module au_add_seq
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             z
);

  localparam int N  = slice_count(WIDTH, DIGIT);
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry_q;
  logic             zero_q;
  logic [CW-1:0]    cnt;

  logic [31:0]      base;
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic [DIGIT-1:0] s_sl;
  logic             c_sl;
  logic             z_sl;
  logic [WIDTH-1:0] next_acc;

  // Bit offset of the slice being worked on in the current CALC cycle.
  always_comb begin
    base = 32'(cnt) * 32'(DIGIT);
  end

  // Pick the current operand slices out of the latched operands; the
  // operand registers themselves are never shifted or overwritten in CALC.
  always_comb begin
    a_sl = a_q[base +: DIGIT];
    b_sl = b_q[base +: DIGIT];
  end

  au_add_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (a_sl),
    .b    (b_sl),
    .ci   (carry_q),
    .s    (s_sl),
    .co   (c_sl),
    .zero (z_sl)
  );

  // Partial sum with the current slice merged in; becomes the result on the last slice.
  always_comb begin
    next_acc = acc;
    next_acc[base +: DIGIT] = s_sl;
  end

  // Controller, datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      co        <= 1'b0;
      z         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= ci;
            zero_q   <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= ST_CALC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_CALC: begin
          acc     <= next_acc;
          carry_q <= c_sl;
          zero_q  <= zero_q & z_sl;
          if (cnt == LAST) begin
            // Last slice: publish the completed result and raise out_valid.
            s         <= next_acc;
            co        <= c_sl;
            z         <= zero_q & z_sl;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            // Result consumed; new operands can only be taken from the next cycle on.
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
